// File: rtl/vm_pkg.sv
// Shared types for the change dispenser: coin denominations, payout status codes
// and dispenser FSM states.
package vm_pkg;

  typedef enum logic [1:0] {
    DEN_NONE = 2'b00,
    DEN_1    = 2'b01,
    DEN_2    = 2'b10,
    DEN_3    = 2'b11
  } denom_t;

  // ST_JAM shares its code with ST_IDLE; done=1 tells them apart.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;
  localparam logic [1:0] ST_SHORT = 2'b01;
  localparam logic [1:0] ST_JAM   = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_DISPENSE,
    S_DONE
  } disp_state_t;

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Request, restock, hopper and result signals of the change dispenser.
// req and load transfer on a cycle where valid && ready; a coin transfers on a
// cycle where coin_valid && coin_ack, with coin_valid/coin_denom held until then.
interface vm_change_dispenser_if #(
  parameter int AMT_W = 8,
  parameter int CNT_W = 4
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             load_valid;
  logic [1:0]       load_denom;
  logic [CNT_W-1:0] load_count;
  logic             load_ready;
  logic             coin_valid;
  logic [1:0]       coin_denom;
  logic             coin_ack;
  logic             done;
  logic [1:0]       status;
  logic [AMT_W-1:0] remaining;
  logic [3*CNT_W-1:0] stock;

  modport master (
    output req_valid, req_amount, load_valid, load_denom, load_count, coin_ack,
    input  req_ready, load_ready, coin_valid, coin_denom, done, status, remaining, stock
  );

  modport slave (
    input  req_valid, req_amount, load_valid, load_denom, load_count, coin_ack,
    output req_ready, load_ready, coin_valid, coin_denom, done, status, remaining, stock
  );
endinterface

// File: rtl/vm_coin_stock.sv
// Per-denomination hopper stock: overwrite on load, single decrement per dispensed
// coin, nonzero flags for the greedy selector and the flat {cnt3, cnt2, cnt1} view.
module vm_coin_stock
  import vm_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  denom_t             load_denom,
  input  logic [CNT_W-1:0]   load_count,
  input  logic               dec_en,
  input  denom_t             dec_denom,
  output logic [3:1]         nz,
  output logic [3*CNT_W-1:0] stock
);
  logic [CNT_W-1:0] cnt1, cnt2, cnt3;

  // Load only happens in IDLE and decrement only in DISPENSE, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (load_en) begin
      case (load_denom)
        DEN_1:   cnt1 <= load_count;
        DEN_2:   cnt2 <= load_count;
        DEN_3:   cnt3 <= load_count;
        default: ;
      endcase
    end else if (dec_en) begin
      case (dec_denom)
        DEN_1:   cnt1 <= cnt1 - CNT_W'(1);
        DEN_2:   cnt2 <= cnt2 - CNT_W'(1);
        DEN_3:   cnt3 <= cnt3 - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign nz    = {cnt3 != '0, cnt2 != '0, cnt1 != '0};
  assign stock = {cnt3, cnt2, cnt1};
endmodule

// File: rtl/vm_change_dispenser.sv
// Greedy change payout FSM driving a coin hopper one coin at a time.
// Optional VM_ACK_TIMEOUT_EN: abort with jam status if coin_ack never arrives.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int CNT_W = 4
`ifdef VM_ACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  vm_change_dispenser_if.slave  bus,
  output disp_state_t           dbg_state
);
  disp_state_t      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d, rem_after;
  denom_t           denom_q, denom_d, sel;
  logic [1:0]       fin_q, fin_d;
  logic             load_en, dec_en;
  logic [3:1]       nz;

  vm_coin_stock #(.CNT_W(CNT_W)) u_stock (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_denom (denom_t'(bus.load_denom)),
    .load_count (bus.load_count),
    .dec_en     (dec_en),
    .dec_denom  (denom_q),
    .nz         (nz),
    .stock      (bus.stock)
  );

`ifdef VM_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timed_out;
  assign tcnt_d    = (state_q == S_DISPENSE && !bus.coin_ack) ? tcnt_q + TW'(1) : '0;
  assign timed_out = (tcnt_q == TW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      denom_q <= DEN_NONE;
      fin_q   <= ST_IDLE;
`ifdef VM_ACK_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      denom_q <= denom_d;
      fin_q   <= fin_d;
`ifdef VM_ACK_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Largest affordable denomination that is still in stock.
  always_comb begin
    sel = DEN_NONE;
    if (rem_q >= AMT_W'(3) && nz[3])      sel = DEN_3;
    else if (rem_q >= AMT_W'(2) && nz[2]) sel = DEN_2;
    else if (rem_q != '0 && nz[1])        sel = DEN_1;
  end

  assign rem_after = rem_q - {{(AMT_W-2){1'b0}}, denom_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    denom_d = denom_q;
    fin_d   = fin_q;
    load_en = 1'b0;
    dec_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load_valid) begin
          load_en = (bus.load_denom != 2'b00);
        end else if (bus.req_valid) begin
          rem_d = bus.req_amount;
          if (bus.req_amount == '0) begin
            fin_d   = ST_FULL;
            state_d = S_DONE;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (sel != DEN_NONE) begin
          denom_d = sel;
          state_d = S_DISPENSE;
        end else begin
          fin_d   = ST_SHORT;
          state_d = S_DONE;
        end
      end
      S_DISPENSE: begin
        if (bus.coin_ack) begin
          dec_en = 1'b1;
          rem_d  = rem_after;
          if (rem_after == '0) begin
            fin_d   = ST_FULL;
            state_d = S_DONE;
          end else begin
            state_d = S_SELECT;
          end
        end
`ifdef VM_ACK_TIMEOUT_EN
        else if (timed_out) begin
          fin_d   = ST_JAM;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_SELECT, S_DISPENSE: bus.status = ST_BUSY;
      S_DONE:               bus.status = fin_q;
      default:              bus.status = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE) && !bus.load_valid;
  assign bus.load_ready = (state_q == S_IDLE);
  assign bus.coin_valid = (state_q == S_DISPENSE);
  assign bus.coin_denom = denom_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.remaining  = rem_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: stimulus pushes expected coins and payout
// results into queues; a negedge monitor pops and compares on each handshake/done.
module tb_vm_change_dispenser;
  import vm_pkg::*;

  localparam int AMT_W = 8;
  localparam int CNT_W = 4;
  localparam int DW    = 2 + AMT_W + 3*CNT_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  disp_state_t dbg_state;

  vm_change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  vm_change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int             n_vec  = 0;
  int             n_fail = 0;
  logic [1:0]     exp_coin_q[$];
  logic [DW-1:0]  exp_done_q[$];
  int             ack_delay = 0;
  bit             ack_en    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [1:0] st, input logic [AMT_W-1:0] rem,
                                         input logic [3:0] c3, input logic [3:0] c2,
                                         input logic [3:0] c1);
    return {st, rem, c3, c2, c1};
  endfunction

  // ---------------- hopper model ----------------
  initial begin
    int w;
    w = 0;
    bus.coin_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.coin_ack = 1'b0;
        w = 0;
      end else if (bus.coin_ack) begin
        bus.coin_ack = 1'b0;
      end else if (bus.coin_valid && ack_en) begin
        if (w >= ack_delay) begin
          bus.coin_ack = 1'b1;
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic       prev_stall = 1'b0;
  logic [1:0] prev_den   = 2'b00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.coin_valid, 1);
        check("hold_denom", bus.coin_denom, prev_den);
      end
      if (bus.coin_valid) check("busy_status", bus.status, ST_BUSY);
      if (bus.coin_valid && bus.coin_ack) begin
        if (exp_coin_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL coin: unexpected coin denom %0d", bus.coin_denom);
        end else begin
          check("coin", bus.coin_denom, exp_coin_q.pop_front());
        end
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL done: unexpected done status %0b remaining %0d", bus.status, bus.remaining);
        end else begin
          check("done_result", {bus.status, bus.remaining, bus.stock}, exp_done_q.pop_front());
        end
      end
      prev_stall = bus.coin_valid && !bus.coin_ack;
      prev_den   = bus.coin_denom;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [1:0] d, input logic [3:0] c);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b1;
    bus.load_denom = d;
    bus.load_count = c;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic request(input logic [AMT_W-1:0] amt);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_amount = amt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("req_accept", ok, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_done_q.size() != 0; i++) @(posedge clk);
    check("drain_done_q", exp_done_q.size(), 0);
    @(posedge clk);
  endtask

  task automatic wait_coin();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.coin_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("coin_seen", seen, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.load_valid = 1'b0;
    bus.load_denom = 2'b00;
    bus.load_count = '0;

    repeat (2) @(negedge clk);
    check("rst_done",   bus.done, 0);
    check("rst_status", bus.status, ST_IDLE);
    check("rst_rem",    bus.remaining, 0);
    check("rst_valid",  bus.coin_valid, 0);
    check("rst_denom",  bus.coin_denom, 0);
    check("rst_stock",  bus.stock, 0);
    check("rst_state",  dbg_state, S_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // greedy payout of 7 from full stock
    load(2'd3, 4'd4);
    load(2'd2, 4'd4);
    load(2'd1, 4'd4);
    exp_coin_q.push_back(2'd3);
    exp_coin_q.push_back(2'd3);
    exp_coin_q.push_back(2'd1);
    exp_done_q.push_back(pack(ST_FULL, 8'd0, 4'd2, 4'd4, 4'd3));
    request(8'd7);
    wait_done();

    // stock runs out: 5 requested, only one 2-coin available
    load(2'd3, 4'd0);
    load(2'd2, 4'd1);
    load(2'd1, 4'd0);
    exp_coin_q.push_back(2'd2);
    exp_done_q.push_back(pack(ST_SHORT, 8'd3, 4'd0, 4'd0, 4'd0));
    request(8'd5);
    wait_done();

    // zero request finishes on the cycle after acceptance
    exp_done_q.push_back(pack(ST_FULL, 8'd0, 4'd0, 4'd0, 4'd0));
    request(8'd0);
    @(negedge clk);
    check("zero_done_timing", bus.done, 1);
    wait_done();

    // slow hopper with a load attempt while dispensing; denom 00 load ignored
    ack_delay = 4;
    load(2'd3, 4'd2);
    load(2'd1, 4'd1);
    load(2'd0, 4'd9);
    exp_coin_q.push_back(2'd3);
    exp_coin_q.push_back(2'd1);
    exp_done_q.push_back(pack(ST_FULL, 8'd0, 4'd1, 4'd0, 4'd0));
    request(8'd4);
    wait_coin();
    @(posedge clk);
    #1;
    bus.load_valid = 1'b1;
    bus.load_denom = 2'd2;
    bus.load_count = 4'd9;
    bus.req_valid  = 1'b1;
    bus.req_amount = 8'd9;
    @(negedge clk);
    check("load_ready_busy", bus.load_ready, 0);
    check("req_ready_busy",  bus.req_ready, 0);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.req_valid  = 1'b0;
    wait_done();
    ack_delay = 0;

    // load and request together: load wins, request accepted next cycle
    exp_coin_q.push_back(2'd1);
    exp_coin_q.push_back(2'd1);
    exp_done_q.push_back(pack(ST_FULL, 8'd0, 4'd1, 4'd0, 4'd0));
    @(posedge clk);
    #1;
    bus.load_valid = 1'b1;
    bus.load_denom = 2'd1;
    bus.load_count = 4'd2;
    bus.req_valid  = 1'b1;
    bus.req_amount = 8'd2;
    @(negedge clk);
    check("req_ready_vs_load", bus.req_ready, 0);
    check("load_ready_idle",   bus.load_ready, 1);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    check("req_ready_after_load", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_done();

`ifdef VM_ACK_TIMEOUT_EN
    // hopper never acknowledges: jam, nothing consumed
    ack_en = 1'b0;
    load(2'd2, 4'd3);
    exp_done_q.push_back(pack(ST_JAM, 8'd2, 4'd1, 4'd3, 4'd0));
    request(8'd2);
    wait_done();
    ack_en = 1'b1;
`endif

    // reset in the middle of a dispense aborts immediately
    ack_en = 1'b0;
    load(2'd2, 4'd3);
    request(8'd2);
    wait_coin();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  bus.coin_valid, 0);
    check("mid_rst_denom",  bus.coin_denom, 0);
    check("mid_rst_stock",  bus.stock, 0);
    check("mid_rst_rem",    bus.remaining, 0);
    check("mid_rst_done",   bus.done, 0);
    check("mid_rst_status", bus.status, ST_IDLE);
    check("mid_rst_state",  dbg_state, S_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(posedge clk);

    check("coin_q_empty", exp_coin_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
